// File: rtl/serial_bit_feeder_pkg.sv
// Shared encodings and helpers for the serial bit feeder.
// Optional parity feature: SERIAL_FEEDER_PARITY_EN (see serial_bit_feeder.sv).
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Producer-to-feeder word handshake (transfer on din_valid && din_ready at the clk edge).
interface serial_bit_feeder_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_bit_feeder_piso_shift.sv
// Parallel-in/serial-out register; the serial bit is a direct flop output.
module piso_shift #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] data,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shifted_s;

  // shift_in enters at the far end so it surfaces right after the last data bit
  if (MSB_FIRST) begin : g_msb
    assign shifted_s = {shreg_r[WIDTH-2:0], shift_in};
    assign out_bit   = shreg_r[WIDTH-1];
  end else begin : g_lsb
    assign shifted_s = {shift_in, shreg_r[WIDTH-1:1]};
    assign out_bit   = shreg_r[0];
  end

  // Load/shift/clear register
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r <= '0;
    end else if (clear) begin
      shreg_r <= '0;
    end else if (load) begin
      shreg_r <= data;
    end else if (shift) begin
      shreg_r <= shifted_s;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Serialises handshaked parallel words onto a 1-bit stream, gapless when a word is pending.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit to every word.
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  serial_bit_feeder_if.slave  word_bus,
  output logic                sout,
  output logic                sout_valid,
  output logic                word_done,
  output logic                busy
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pend_r;
  logic             pend_valid_r, pend_valid_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic             sout_valid_r, sout_valid_s;
  logic             word_done_r, word_done_s;
  logic             busy_r;
  logic             ready_s, accept_s, take_s, load_s, shift_s, clear_s, end_word_s;
  logic             shift_in_s;

  assign ready_s            = !pend_valid_r && !reset;
  assign word_bus.din_ready = ready_s;
  assign accept_s           = word_bus.din_valid && ready_s;

`ifdef SERIAL_FEEDER_PARITY_EN
  logic par_r;

  // Parity of the word being serialised, captured as it enters the shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      par_r <= 1'b0;
    end else if (load_s) begin
      par_r <= even_parity(64'(pend_r));
    end
  end

  assign shift_in_s = par_r;
`else
  assign shift_in_s = 1'b0;
`endif

  // Next-state and control decode
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    sout_valid_s = sout_valid_r;
    word_done_s  = 1'b0;
    take_s       = 1'b0;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    clear_s      = 1'b0;
    end_word_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pend_valid_r) begin
          take_s       = 1'b1;
          load_s       = 1'b1;
          bit_cnt_s    = '0;
          sout_valid_s = 1'b1;
          state_s      = ST_SHIFT;
        end else begin
          sout_valid_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_r != LAST_CNT) begin
          shift_s   = 1'b1;
          bit_cnt_s = bit_cnt_r + CNT_W'(1);
`ifndef SERIAL_FEEDER_PARITY_EN
          word_done_s = (bit_cnt_s == LAST_CNT);
`endif
        end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
          shift_s     = 1'b1;
          bit_cnt_s   = bit_cnt_r + CNT_W'(1);
          word_done_s = 1'b1;
          state_s     = ST_PAR;
`else
          end_word_s  = 1'b1;
`endif
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      ST_PAR: begin
        end_word_s = 1'b1;
      end
`endif
      default: begin
        state_s      = ST_IDLE;
        clear_s      = 1'b1;
        sout_valid_s = 1'b0;
      end
    endcase

    // A waiting word follows the last bit with no idle cycle
    if (end_word_s) begin
      if (pend_valid_r) begin
        take_s       = 1'b1;
        load_s       = 1'b1;
        bit_cnt_s    = '0;
        sout_valid_s = 1'b1;
        state_s      = ST_SHIFT;
      end else begin
        clear_s      = 1'b1;
        sout_valid_s = 1'b0;
        state_s      = ST_IDLE;
      end
    end else begin
      end_word_s = 1'b0;
    end

    if (accept_s) begin
      pend_valid_s = 1'b1;
    end else if (take_s) begin
      pend_valid_s = 1'b0;
    end else begin
      pend_valid_s = pend_valid_r;
    end
  end

  // State, counter, holding register and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= '0;
      pend_r       <= '0;
      pend_valid_r <= 1'b0;
      sout_valid_r <= 1'b0;
      word_done_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      pend_valid_r <= pend_valid_s;
      sout_valid_r <= sout_valid_s;
      word_done_r  <= word_done_s;
      busy_r       <= (state_s != ST_IDLE) || pend_valid_s;
      if (accept_s) begin
        pend_r <= word_bus.din;
      end
    end
  end

  piso_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .load     (load_s),
    .shift    (shift_s),
    .shift_in (shift_in_s),
    .data     (pend_r),
    .out_bit  (sout)
  );

  assign sout_valid = sout_valid_r;
  assign word_done  = word_done_r;
  assign busy       = busy_r;

endmodule
